// File: rtl/mpsoc_wb_pkg.sv
// mpsoc_wb_pkg: Wishbone B3 cycle-type/burst-type encodings and burst master state type.
package mpsoc_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'd0;
  localparam logic [1:0] BTE_WRAP4   = 2'd1;
  localparam logic [1:0] BTE_WRAP8   = 2'd2;
  localparam logic [1:0] BTE_WRAP16  = 2'd3;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
endpackage

// File: rtl/mpsoc_wb_next_adr.sv
// mpsoc_wb_next_adr: next beat byte address, wrapping the low word bits for wrap bursts.
module mpsoc_wb_next_adr
  import mpsoc_wb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [AW-1:0] adr_o
);
  localparam int WW = AW - 2;
  logic [WW-1:0] w, inc, mask;
  always_comb begin
    w     = adr_i[AW-1:2];
    inc   = w + 1'b1;
    mask  = bte_i == BTE_WRAP4  ? WW'(3)  :
            bte_i == BTE_WRAP8  ? WW'(7)  :
            bte_i == BTE_WRAP16 ? WW'(15) : '1;
    adr_o = {(w & ~mask) | (inc & mask), adr_i[1:0]};
  end
endmodule

// File: rtl/mpsoc_wb_burst_master.sv
// mpsoc_wb_burst_master: Wishbone B3 initiator turning one command into a classic or incrementing burst cycle.
module mpsoc_wb_burst_master
  import mpsoc_wb_pkg::*;
#(
  parameter int  AW        = 32,
  parameter int  DW        = 32,
  parameter int  MAX_BURST = 16,
  localparam int LW        = $clog2(MAX_BURST + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_adr,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_we,
  input  logic [1:0]    cmd_bte,
  input  logic [3:0]    cmd_sel,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          done_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BURST);
  state_t        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d, adr_nx;
  logic [DW-1:0] dat_q, dat_d, rdd_q, rdd_d;
  logic [3:0]    sel_q, sel_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic          we_q, we_d, cyc_q, cyc_d, stb_q, stb_d, err_q, err_d, rdv_q, rdv_d;
  logic [LW-1:0] len_q, len_d, iss_q, iss_d, cmp_q, cmp_d, cmp_nx;
  logic          beat_ack, beat_err, last;
  mpsoc_wb_next_adr #(.AW(AW)) u_next_adr (
    .adr_i(adr_q),
    .bte_i(bte_q),
    .adr_o(adr_nx)
  );
  // ack together with err is treated as an error beat
  assign beat_err  = cyc_q & stb_q & wb_err_i;
  assign beat_ack  = cyc_q & stb_q & wb_ack_i & ~wb_err_i;
  assign cmp_nx    = cmp_q + 1'b1;
  assign last      = cmp_nx == len_q;
  assign wr_ready  = state_q == BUS && we_q && iss_q != len_q && (!stb_q || beat_ack);
  assign cmd_ready = state_q == IDLE;
  assign done      = state_q == DONE;
  assign done_err  = done & err_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdd_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cti_o  = cti_q;
  assign wb_bte_o  = bte_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    len_d   = len_q;
    iss_d   = iss_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        len_d   = cmd_len;
        adr_d   = cmd_adr;
        sel_d   = cmd_sel;
        we_d    = cmd_we;
        bte_d   = cmd_bte;
        iss_d   = '0;
        cmp_d   = '0;
        err_d   = cmd_len > MAX_LEN;
        cti_d   = cmd_len == LW'(1) ? CTI_CLASSIC : CTI_INCR;
        state_d = (cmd_len == '0 || cmd_len > MAX_LEN) ? DONE : BUS;
        cyc_d   = state_d == BUS;
        // writes hold stb low until the first data word arrives
        stb_d   = state_d == BUS && !cmd_we;
      end
      BUS: if (beat_err) begin
        state_d = DONE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        err_d   = 1'b1;
      end else begin
        if (beat_ack) begin
          cmp_d = cmp_nx;
          adr_d = adr_nx;
          rdv_d = !we_q;
          rdd_d = wb_dat_i;
          cti_d = cmp_nx == len_q - 1'b1 ? CTI_EOB : CTI_INCR;
          if (last) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end
        end
        if (wr_ready) begin
          stb_d = wr_valid;
          dat_d = wr_valid ? wr_data : dat_q;
          iss_d = wr_valid ? iss_q + 1'b1 : iss_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      bte_q   <= BTE_LINEAR;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      len_q   <= '0;
      iss_q   <= '0;
      cmp_q   <= '0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end
endmodule

// File: tb/tb_mpsoc_wb_burst_master.sv
// tb_mpsoc_wb_burst_master: scoreboard bench with a memory slave acking every other cycle.
module tb_mpsoc_wb_burst_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int LW = 5;
  localparam int WW = AW - 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_we = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [1:0] cmd_bte = '0;
  logic [3:0] cmd_sel = '0;
  logic [DW-1:0] wr_data = '0;
  logic cmd_ready, wr_ready, rd_valid, done, done_err;
  logic [DW-1:0] rd_data, wb_dat_o, wb_dat_i;
  logic [AW-1:0] wb_adr;
  logic [3:0] wb_sel;
  logic [2:0] wb_cti;
  logic [1:0] wb_bte;
  logic wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  mpsoc_wb_burst_master #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .cmd_we(cmd_we), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cti_o(wb_cti), .wb_bte_o(wb_bte), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );
  logic [DW-1:0] mem [64];
  int err_beat = 0;
  int sbeat;
  assign wb_dat_i = mem[wb_adr[7:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      sbeat  <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i);
    end else begin
      if (wb_cyc && wb_stb && wb_we && wb_ack) mem[wb_adr[7:2]] <= wb_dat_o;
      if (!wb_cyc) sbeat <= 0;
      else if (wb_stb && (wb_ack || wb_err)) sbeat <= sbeat + 1;
      wb_ack <= wb_cyc && wb_stb && !wb_ack && !wb_err && (sbeat + 1 != err_beat);
      wb_err <= wb_cyc && wb_stb && !wb_ack && !wb_err && (sbeat + 1 == err_beat);
    end
  end
  int checks = 0, failures = 0;
  logic mon_en = 1'b1;
  logic [AW-1:0] exp_adr[$];
  logic [2:0] exp_cti[$];
  logic [DW-1:0] exp_rd[$];
  logic [AW-1:0] m_adr;
  logic [2:0] m_cti;
  logic [DW-1:0] m_rd;
  logic [3:0] cur_sel;
  logic cur_we;
  logic [1:0] cur_bte;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (wb_cyc && wb_stb && wb_ack && !wb_err) begin
        checks++;
        if (exp_adr.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected adr=%h", wb_adr);
        end else begin
          m_adr = exp_adr.pop_front();
          m_cti = exp_cti.pop_front();
          if (wb_adr !== m_adr) begin failures++; $display("FAIL beat_adr got=%h want=%h", wb_adr, m_adr); end
          checks++;
          if (wb_cti !== m_cti) begin failures++; $display("FAIL beat_cti adr=%h got=%b want=%b", wb_adr, wb_cti, m_cti); end
          checks++;
          if ({wb_sel, wb_we, wb_bte} !== {cur_sel, cur_we, cur_bte})
            begin failures++; $display("FAIL beat_attr got=%h/%b/%0d want=%h/%b/%0d", wb_sel, wb_we, wb_bte, cur_sel, cur_we, cur_bte); end
        end
      end
      if (rd_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected data=%h", rd_data);
        end else begin
          m_rd = exp_rd.pop_front();
          if (rd_data !== m_rd) begin failures++; $display("FAIL rd_data got=%h want=%h", rd_data, m_rd); end
        end
      end
    end
  end
  logic [DW-1:0] model [64];
  logic [DW-1:0] wq[$];
  int stall_after = -1, stall_n = 0;
  int lat, nrd, nack, gap_n, err_c;
  logic d_seen, d_err, d_after, cyc_seen, rdy_busy;
  logic [AW-1:0] gap_adr;
  function automatic logic [AW-1:0] beat_adr(input logic [AW-1:0] a, input logic [1:0] bte, input int i);
    int n;
    logic [WW-1:0] w;
    n = (bte == 2'd0) ? 0 : (2 << bte);
    w = a[AW-1:2];
    w = (n == 0) ? w + WW'(i) : (w / WW'(n)) * WW'(n) + WW'((int'(w % WW'(n)) + i) % n);
    return {w, 2'b00};
  endfunction
  task automatic do_cmd(input logic [AW-1:0] a, input int len, input logic we, input logic [1:0] bte,
                        input logic [3:0] sel, input logic hold);
    int nwr = 0, stl = stall_n;
    logic [AW-1:0] ba;
    logic [DW-1:0] wdat[$];
    wdat = wq;
    cur_sel = sel; cur_we = we; cur_bte = bte;
    if (len >= 1 && len <= MB)
      for (int i = 0; i < len; i++) begin
        ba = beat_adr(a, bte, i);
        exp_adr.push_back(ba);
        exp_cti.push_back(len == 1 ? 3'b000 : (i == len - 1) ? 3'b111 : 3'b010);
        if (!we) exp_rd.push_back(model[ba[7:2]]);
      end
    d_seen = 0; d_err = 0; d_after = 0; cyc_seen = 0; rdy_busy = 0;
    lat = -1; err_c = -1; nrd = 0; nack = 0; gap_n = 0; gap_adr = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_adr = a; cmd_len = LW'(len); cmd_we = we; cmd_bte = bte; cmd_sel = sel;
    @(posedge clk);
    for (int c = 0; c < 400 && !d_seen; c++) begin
      @(negedge clk);
      if (done) begin d_seen = 1; d_err = done_err; lat = c; end
      if (hold && !d_seen) begin
        cmd_adr = ~a; cmd_we = !we; cmd_bte = ~bte; cmd_sel = ~sel; cmd_len = LW'(1);
      end else cmd_valid = 1'b0;
      rdy_busy |= cmd_ready;
      cyc_seen |= wb_cyc;
      if (rd_valid) nrd++;
      if (wb_cyc && wb_stb && wb_err) err_c = c;
      if (wb_cyc && wb_stb && wb_ack && !wb_err) nack++;
      if (wb_cyc && !wb_stb && nack > 0) begin
        if (gap_n == 0) gap_adr = wb_adr;
        gap_n++;
      end
      if (we && wq.size() > 0 && nwr == stall_after && stl > 0 && wr_ready) begin
        wr_valid = 1'b0;
        stl--;
      end else wr_valid = we && wq.size() > 0 && !d_seen;
      wr_data = wq.size() > 0 ? wq[0] : '0;
      if (wr_valid && wr_ready) begin
        void'(wq.pop_front());
        nwr++;
      end
    end
    wr_valid = 1'b0;
    cmd_valid = 1'b0;
    if (we)
      for (int i = 0; i < nack; i++) begin
        ba = beat_adr(a, bte, i);
        model[ba[7:2]] = wdat[i];
      end
    if (d_seen) begin
      @(negedge clk);
      d_after = done;
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 64; i++) model[i] = DW'(i);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    checks++;
    if ({wb_cyc, wb_stb, wb_we, done, done_err, rd_valid, wr_ready} !== 7'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b want=0", {wb_cyc, wb_stb, wb_we, done, done_err, rd_valid, wr_ready}); end
    checks++;
    if ({wb_adr, wb_dat_o, wb_sel, wb_cti, wb_bte} !== '0)
      begin failures++; $display("FAIL reset_bus got=%h/%h/%h/%b/%b want=0", wb_adr, wb_dat_o, wb_sel, wb_cti, wb_bte); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL reset_release ready=%b cyc=%b want=1/0", cmd_ready, wb_cyc); end
  endtask
  task automatic test_single_write;
    wq = '{32'hCAFEF00D};
    do_cmd(32'h10, 1, 1'b1, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || d_err !== 1'b0) begin failures++; $display("FAIL single_wr_done seen=%b err=%b want=1/0", d_seen, d_err); end
    checks++;
    if (mem[4] !== 32'hCAFEF00D) begin failures++; $display("FAIL single_wr_mem got=%h want=cafef00d", mem[4]); end
    checks++;
    if (d_after !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b want=0", d_after); end
    do_cmd(32'h10, 1, 1'b0, 2'd0, 4'h3, 1'b0);
    checks++;
    if (nrd != 1 || d_err !== 1'b0) begin failures++; $display("FAIL single_rd nrd=%0d err=%b want=1/0", nrd, d_err); end
  endtask
  task automatic test_linear_read;
    do_cmd(32'h0, 4, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || nrd != 4) begin failures++; $display("FAIL lin_rd seen=%b nrd=%0d want=1/4", d_seen, nrd); end
    checks++;
    if (exp_adr.size() != 0 || exp_rd.size() != 0) begin failures++; $display("FAIL lin_rd_drain beats=%0d rds=%0d want=0/0", exp_adr.size(), exp_rd.size()); end
  endtask
  task automatic test_wrap4_write;
    wq = '{32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0000, 32'hA0A0_0001};
    do_cmd(32'h08, 4, 1'b1, 2'd1, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || d_err !== 1'b0 || exp_adr.size() != 0) begin failures++; $display("FAIL wrap4_wr seen=%b err=%b left=%0d want=1/0/0", d_seen, d_err, exp_adr.size()); end
    do_cmd(32'h0, 4, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (nrd != 4) begin failures++; $display("FAIL wrap4_readback nrd=%0d want=4", nrd); end
  endtask
  task automatic test_write_stall;
    stall_after = 2; stall_n = 3;
    wq = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    do_cmd(32'h20, 4, 1'b1, 2'd0, 4'hC, 1'b0);
    stall_after = -1; stall_n = 0;
    checks++;
    if (gap_n != 3) begin failures++; $display("FAIL stall_gap_len got=%0d want=3", gap_n); end
    checks++;
    if (gap_adr !== 32'h28) begin failures++; $display("FAIL stall_gap_adr got=%h want=00000028", gap_adr); end
    checks++;
    if (d_seen !== 1'b1 || d_err !== 1'b0 || nack != 4) begin failures++; $display("FAIL stall_done seen=%b err=%b acks=%0d want=1/0/4", d_seen, d_err, nack); end
    do_cmd(32'h20, 4, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (nrd != 4) begin failures++; $display("FAIL stall_readback nrd=%0d want=4", nrd); end
  endtask
  task automatic test_error;
    err_beat = 2;
    do_cmd(32'h0, 8, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || d_err !== 1'b1) begin failures++; $display("FAIL err_rd_done seen=%b err=%b want=1/1", d_seen, d_err); end
    checks++;
    if (nrd != 1) begin failures++; $display("FAIL err_rd_count got=%0d want=1", nrd); end
    checks++;
    if (lat - err_c != 1) begin failures++; $display("FAIL err_to_done got=%0d want=1", lat - err_c); end
    checks++;
    if (exp_adr.size() != 7) begin failures++; $display("FAIL err_beats_left got=%0d want=7", exp_adr.size()); end
    exp_adr.delete(); exp_cti.delete(); exp_rd.delete();
    wq = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    do_cmd(32'h40, 4, 1'b1, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_err !== 1'b1 || wq.size() != 2) begin failures++; $display("FAIL err_wr err=%b left_data=%0d want=1/2", d_err, wq.size()); end
    err_beat = 0;
    wq.delete(); exp_adr.delete(); exp_cti.delete(); exp_rd.delete();
  endtask
  task automatic test_edge_len;
    do_cmd(32'h0, 0, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || lat != 0 || d_err !== 1'b0 || cyc_seen !== 1'b0)
      begin failures++; $display("FAIL len0 seen=%b lat=%0d err=%b cyc=%b want=1/0/0/0", d_seen, lat, d_err, cyc_seen); end
    do_cmd(32'h0, 17, 1'b1, 2'd0, 4'hF, 1'b0);
    checks++;
    if (d_seen !== 1'b1 || lat != 0 || d_err !== 1'b1 || cyc_seen !== 1'b0)
      begin failures++; $display("FAIL len17 seen=%b lat=%0d err=%b cyc=%b want=1/0/1/0", d_seen, lat, d_err, cyc_seen); end
    do_cmd(32'h0, 16, 1'b0, 2'd0, 4'hF, 1'b0);
    checks++;
    if (nrd != 16 || d_err !== 1'b0) begin failures++; $display("FAIL len16 nrd=%0d err=%b want=16/0", nrd, d_err); end
  endtask
  task automatic test_back_to_back;
    do_cmd(32'h0, 4, 1'b0, 2'd0, 4'h5, 1'b1);
    checks++;
    if (rdy_busy !== 1'b0 || nrd != 4) begin failures++; $display("FAIL busy_ready ready=%b nrd=%0d want=0/4", rdy_busy, nrd); end
    do_cmd(32'h38, 8, 1'b0, 2'd2, 4'hF, 1'b0);
    checks++;
    if (nrd != 8) begin failures++; $display("FAIL wrap8_rd nrd=%0d want=8", nrd); end
    do_cmd(32'h3C, 16, 1'b0, 2'd3, 4'hF, 1'b0);
    checks++;
    if (nrd != 16 || exp_adr.size() != 0) begin failures++; $display("FAIL wrap16_rd nrd=%0d left=%0d want=16/0", nrd, exp_adr.size()); end
  endtask
  task automatic test_reset_mid_burst;
    mon_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_adr = 32'h0; cmd_len = LW'(8); cmd_we = 1'b0; cmd_bte = 2'd0; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b1) begin failures++; $display("FAIL mid_burst_active cyc=%b want=1", wb_cyc); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, wb_adr, wb_cti, rd_valid, done} !== '0)
      begin failures++; $display("FAIL async_reset cyc=%b stb=%b adr=%h cti=%b want=0", wb_cyc, wb_stb, wb_adr, wb_cti); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b want=1", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = DW'(i);
    mon_en = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_linear_read();
    test_single_write();
    test_wrap4_write();
    test_write_stall();
    test_error();
    test_edge_len();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
